// File: rtl/pet_spi_pkg.sv
// Shared definitions for the SPI1 command target.
// Holds the command opcode encoding, the FSM state encoding, the number
// of bytes each command carries and the bit positions used by SET_CPU.
package pet_spi_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_RSVD    = 2'b10,
    OP_SET_CPU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RECV  = 2'b01,
    ST_ISSUE = 2'b10
  } state_e;

  localparam logic [2:0] READ_BYTES    = 3'd3;
  localparam logic [2:0] WRITE_BYTES   = 3'd4;
  localparam logic [2:0] SET_CPU_BYTES = 3'd1;
  localparam logic [2:0] RSVD_BYTES    = 3'd1;

  // SET_CPU payload bit positions inside the command byte
  localparam int CPU_READY_BIT = 1;
  localparam int CPU_RESET_BIT = 0;

  // Total command length in bytes, including the command byte itself
  function automatic logic [2:0] op_bytes(input op_e op);
    logic [2:0] n;
    case (op)
      OP_READ:    n = READ_BYTES;
      OP_WRITE:   n = WRITE_BYTES;
      OP_SET_CPU: n = SET_CPU_BYTES;
      OP_RSVD:    n = RSVD_BYTES;
      default:    n = RSVD_BYTES;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sync2.sv
// Multi-bit flop-chain synchronizer with a per-bit reset value.
// Ports:
//   clk   in  sampling clock
//   rst_n in  asynchronous active-low reset
//   d     in  WIDTH asynchronous inputs
//   q     out WIDTH synchronized outputs, STAGES clocks behind d
module sync2 #(
  parameter int              WIDTH   = 1,
  parameter int              STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe_r [STAGES];

  // Shift the inputs through the synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        pipe_r[i] <= RST_VAL;
      end
    end else begin
      pipe_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign q = pipe_r[STAGES-1];

endmodule

// File: rtl/spi1_cmd_target.sv
// SPI mode-0 command target: decodes READ / WRITE / SET_CPU commands sent
// by the MCU, issues single bus transactions and controls CPU reset/ready.
// All SPI inputs are oversampled on clk16_i through a synchronizer.
// Ports:
//   clk16_i, reset_ni           system clock and async active-low reset
//   spi1_sck_i/cs_ni/mcu_tx_i   SPI SCK, chip select, MOSI
//   spi1_mcu_rx_o/rx_oe         MISO and its output enable
//   spi_ready_no                low when idle and ready for a command
//   bus_addr_o/data_o/rw_no     transaction address, write data, 1=read
//   bus_valid_o                 request, held until bus_done_i
//   bus_done_i/bus_data_i       completion pulse and read data
//   cpu_reset_o/cpu_ready_o     CPU control outputs
module spi1_cmd_target
  import pet_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk16_i,
  input  logic        reset_ni,
  input  logic        spi1_sck_i,
  input  logic        spi1_cs_ni,
  input  logic        spi1_mcu_tx_i,
  output logic        spi1_mcu_rx_o,
  output logic        spi1_mcu_rx_oe,
  output logic        spi_ready_no,
  output logic [16:0] bus_addr_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_rw_no,
  output logic        bus_valid_o,
  input  logic        bus_done_i,
  input  logic [7:0]  bus_data_i,
  output logic        cpu_reset_o,
  output logic        cpu_ready_o
);

  logic [2:0] sync_out_s;
  logic       sck_s, cs_n_s, mosi_s;
  logic       sck_prev_r, cs_prev_r;
  logic       sample_s, cs_fall_s, accept_s, byte_done_s;

  logic [2:0] bit_cnt_r, byte_cnt_r;
  logic [6:0] shift_r;
  logic [7:0] new_byte_s;
  op_e        cmd_op_r;
  logic       cmd_a16_r;
  logic [7:0] addr_hi_r, addr_lo_r;
  logic       frame_done_r;
  logic [7:0] rd_data_r;
  logic [7:0] miso_sr_r;

  state_e     state_r, state_next_s;
  op_e        cur_op_s;
  logic       cmd_end_s, cmd_is_bus_s;
  logic       issue_s, set_cpu_s;

  sync2 #(
    .WIDTH  (3),
    .STAGES (SYNC_STAGES),
    .RST_VAL(3'b010)
  ) u_sync (
    .clk  (clk16_i),
    .rst_n(reset_ni),
    .d    ({spi1_sck_i, spi1_cs_ni, spi1_mcu_tx_i}),
    .q    (sync_out_s)
  );

  assign sck_s  = sync_out_s[2];
  assign cs_n_s = sync_out_s[1];
  assign mosi_s = sync_out_s[0];

  // MISO drive enable follows the raw chip select so the bus is released at once
  assign spi1_mcu_rx_oe = ~spi1_cs_ni;
  assign spi1_mcu_rx_o  = miso_sr_r[7];

  // Previous synchronized SCK / CS_N for edge detection
  always_ff @(posedge clk16_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sck_prev_r <= 1'b0;
      cs_prev_r  <= 1'b1;
    end else begin
      sck_prev_r <= sck_s;
      cs_prev_r  <= cs_n_s;
    end
  end

  assign sample_s    = sck_s & ~sck_prev_r & ~cs_n_s;
  assign cs_fall_s   = cs_prev_r & ~cs_n_s;
  // Bits are only taken while idle (before a command completed in this
  // CS_N assertion) or while receiving; ISSUE ignores SCK entirely.
  assign accept_s    = sample_s & ((state_r == ST_RECV) |
                                   ((state_r == ST_IDLE) & ~frame_done_r));
  assign byte_done_s = accept_s & (bit_cnt_r == 3'd7);
  assign new_byte_s  = {shift_r, mosi_s};

  // Command decode: the op comes from the byte in flight until byte 0 is stored
  always_comb begin
    if (byte_cnt_r == 3'd0) begin
      cur_op_s = op_e'(new_byte_s[7:6]);
    end else begin
      cur_op_s = cmd_op_r;
    end
    cmd_end_s    = (state_r == ST_RECV) & byte_done_s &
                   (byte_cnt_r == (op_bytes(cur_op_s) - 3'd1));
    cmd_is_bus_s = (cur_op_s == OP_READ) | (cur_op_s == OP_WRITE);
  end

  // FSM state register
  always_ff @(posedge clk16_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = ST_RECV;
        else          state_next_s = ST_IDLE;
      end
      ST_RECV: begin
        if (cs_n_s) begin
          state_next_s = ST_IDLE;
        end else if (cmd_end_s) begin
          if (cmd_is_bus_s) state_next_s = ST_ISSUE;
          else              state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RECV;
        end
      end
      ST_ISSUE: begin
        if (bus_done_i) state_next_s = ST_IDLE;
        else            state_next_s = ST_ISSUE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM output strobes
  always_comb begin
    issue_s   = 1'b0;
    set_cpu_s = 1'b0;
    if (cmd_end_s) begin
      issue_s   = cmd_is_bus_s;
      set_cpu_s = (cur_op_s == OP_SET_CPU);
    end else begin
      issue_s   = 1'b0;
      set_cpu_s = 1'b0;
    end
  end

  // Bit/byte counters, receive shifter and per-byte capture
  always_ff @(posedge clk16_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bit_cnt_r    <= 3'd0;
      byte_cnt_r   <= 3'd0;
      shift_r      <= 7'd0;
      cmd_op_r     <= OP_READ;
      cmd_a16_r    <= 1'b0;
      addr_hi_r    <= 8'd0;
      addr_lo_r    <= 8'd0;
      frame_done_r <= 1'b0;
    end else if (cs_fall_s) begin
      bit_cnt_r    <= 3'd0;
      byte_cnt_r   <= 3'd0;
      shift_r      <= 7'd0;
      frame_done_r <= 1'b0;
    end else begin
      if (accept_s) begin
        shift_r   <= new_byte_s[6:0];
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
      if (byte_done_s) begin
        byte_cnt_r <= byte_cnt_r + 3'd1;
        case (byte_cnt_r)
          3'd0: begin
            cmd_op_r  <= op_e'(new_byte_s[7:6]);
            cmd_a16_r <= new_byte_s[0];
          end
          3'd1:    addr_hi_r <= new_byte_s;
          3'd2:    addr_lo_r <= new_byte_s;
          default: ;
        endcase
      end
      if (cmd_end_s) begin
        frame_done_r <= 1'b1;
      end
    end
  end

  // Bus request: loaded when the final command bit lands, held until done
  always_ff @(posedge clk16_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bus_valid_o <= 1'b0;
      bus_rw_no   <= 1'b1;
      bus_addr_o  <= 17'd0;
      bus_data_o  <= 8'd0;
    end else if (issue_s) begin
      bus_valid_o <= 1'b1;
      if (cur_op_s == OP_READ) begin
        bus_rw_no  <= 1'b1;
        bus_addr_o <= {cmd_a16_r, addr_hi_r, new_byte_s};
      end else begin
        bus_rw_no  <= 1'b0;
        bus_addr_o <= {cmd_a16_r, addr_hi_r, addr_lo_r};
        bus_data_o <= new_byte_s;
      end
    end else if ((state_r == ST_ISSUE) && bus_done_i) begin
      bus_valid_o <= 1'b0;
    end
  end

  // Read data capture on completion of a READ
  always_ff @(posedge clk16_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_data_r <= 8'd0;
    end else if ((state_r == ST_ISSUE) && bus_done_i && bus_rw_no) begin
      rd_data_r <= bus_data_i;
    end
  end

  // MISO shifter: parked on rd_data while deselected so bit 7 is ready at CS_N fall
  always_ff @(posedge clk16_i or negedge reset_ni) begin
    if (!reset_ni) begin
      miso_sr_r <= 8'd0;
    end else if (cs_n_s) begin
      miso_sr_r <= rd_data_r;
    end else if (sample_s) begin
      miso_sr_r <= {miso_sr_r[6:0], 1'b0};
    end
  end

  // CPU control from SET_CPU
  always_ff @(posedge clk16_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cpu_reset_o <= 1'b1;
      cpu_ready_o <= 1'b0;
    end else if (set_cpu_s) begin
      cpu_reset_o <= new_byte_s[CPU_RESET_BIT];
      cpu_ready_o <= new_byte_s[CPU_READY_BIT];
    end
  end

  // Busy flag: high whenever the FSM is (or is about to be) out of IDLE
  always_ff @(posedge clk16_i or negedge reset_ni) begin
    if (!reset_ni) begin
      spi_ready_no <= 1'b1;
    end else begin
      spi_ready_no <= (state_next_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_spi1_cmd_target.sv
`timescale 1ns/1ps
module tb_spi1_cmd_target;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sck, cs_n, mosi;
  logic        miso, miso_oe, ready_n;
  logic [16:0] addr;
  logic [7:0]  wdata;
  logic        rw_n, valid;
  logic        done;
  logic [7:0]  rdata;
  logic        cpu_rst, cpu_rdy;

  int n_checks = 0;
  int n_fail   = 0;

  spi1_cmd_target #(.SYNC_STAGES(2)) dut (
    .clk16_i      (clk),
    .reset_ni     (rst_n),
    .spi1_sck_i   (sck),
    .spi1_cs_ni   (cs_n),
    .spi1_mcu_tx_i(mosi),
    .spi1_mcu_rx_o(miso),
    .spi1_mcu_rx_oe(miso_oe),
    .spi_ready_no (ready_n),
    .bus_addr_o   (addr),
    .bus_data_o   (wdata),
    .bus_rw_no    (rw_n),
    .bus_valid_o  (valid),
    .bus_done_i   (done),
    .bus_data_i   (rdata),
    .cpu_reset_o  (cpu_rst),
    .cpu_ready_o  (cpu_rdy)
  );

  always #31.25 clk = ~clk;

  typedef struct {
    logic [31:0] bytes;   // sent MSB byte first
    int          n;
    logic [16:0] addr;
    logic [7:0]  data;
    logic        rw;
    logic [7:0]  done_d;
    logic [7:0]  rx0;     // first MISO byte expected in this transaction
  } vec_t;

  vec_t vecs[4];

  function automatic vec_t mk(input logic [31:0] b, input int n, input logic [16:0] a,
                              input logic [7:0] d, input logic rw, input logic [7:0] dd,
                              input logic [7:0] rx0);
    vec_t v;
    v.bytes = b; v.n = n; v.addr = a; v.data = d; v.rw = rw; v.done_d = dd; v.rx0 = rx0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI mode-0 byte: MOSI set with SCK low, MISO captured at the rising edge
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      tick(4);
      rx[i] = miso;
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    tick(4);
    cs_n = 1'b1;
    tick(6);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!valid && k < 300) begin
      tick(1);
      k++;
    end
    check(name, {31'd0, valid}, 32'd1);
  endtask

  task automatic pulse_done(input logic [7:0] d);
    done  = 1'b1;
    rdata = d;
    tick(1);
    done  = 1'b0;
    rdata = 8'h00;
  endtask

  initial begin
    logic [7:0]  rxb, rx_first;
    logic [31:0] sh;
    int          highs;

    vecs[0] = mk(32'h4180005A, 4, 17'h18000, 8'h5A, 1'b0, 8'h00, 8'h00);
    vecs[1] = mk(32'h00E81000, 3, 17'h0E810, 8'h5A, 1'b1, 8'hC3, 8'h00);
    vecs[2] = mk(32'h401234A5, 4, 17'h01234, 8'hA5, 1'b0, 8'h00, 8'hC3);
    vecs[3] = mk(32'h01FFFF00, 3, 17'h1FFFF, 8'hA5, 1'b1, 8'h3C, 8'hC3);

    rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; done = 1'b0; rdata = 8'h00;

    // Reset values
    tick(3);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_rw", {31'd0, rw_n}, 32'd1);
    check("rst_addr", {15'd0, addr}, 32'd0);
    check("rst_data", {24'd0, wdata}, 32'd0);
    check("rst_ready_n", {31'd0, ready_n}, 32'd1);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_cpu_rdy", {31'd0, cpu_rdy}, 32'd0);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_oe", {31'd0, miso_oe}, 32'd0);
    rst_n = 1'b1;
    tick(3);
    check("post_rst_ready_n", {31'd0, ready_n}, 32'd0);

    // Table-driven READ/WRITE transactions
    for (int v = 0; v < 4; v++) begin
      cs_low();
      check($sformatf("v%0d_oe", v), {31'd0, miso_oe}, 32'd1);
      rx_first = 8'h00;
      for (int k = 0; k < vecs[v].n; k++) begin
        sh = vecs[v].bytes >> (8 * (3 - k));
        spi_byte(sh[7:0], rxb);
        if (k == 0) rx_first = rxb;
      end
      wait_valid($sformatf("v%0d_valid", v));
      check($sformatf("v%0d_rx0", v), {24'd0, rx_first}, {24'd0, vecs[v].rx0});
      check($sformatf("v%0d_addr", v), {15'd0, addr}, {15'd0, vecs[v].addr});
      check($sformatf("v%0d_data", v), {24'd0, wdata}, {24'd0, vecs[v].data});
      check($sformatf("v%0d_rw", v), {31'd0, rw_n}, {31'd0, vecs[v].rw});
      check($sformatf("v%0d_busy", v), {31'd0, ready_n}, 32'd1);
      tick(2);
      pulse_done(vecs[v].done_d);
      check($sformatf("v%0d_drop", v), {31'd0, valid}, 32'd0);
      check($sformatf("v%0d_idle", v), {31'd0, ready_n}, 32'd0);
      cs_high();
    end

    // SET_CPU 0xC2; MISO returns the last READ data (0x3C)
    cs_low();
    spi_byte(8'hC2, rxb);
    tick(2);
    check("setcpu1_rx0", {24'd0, rxb}, 32'h3C);
    check("setcpu1_rst", {31'd0, cpu_rst}, 32'd0);
    check("setcpu1_rdy", {31'd0, cpu_rdy}, 32'd1);
    check("setcpu1_ready_n", {31'd0, ready_n}, 32'd0);
    cs_high();

    // SET_CPU 0xC1 followed by an extra byte in the same frame (ignored)
    cs_low();
    spi_byte(8'hC1, rxb);
    spi_byte(8'hC2, rxb);
    tick(2);
    check("setcpu2_rst", {31'd0, cpu_rst}, 32'd1);
    check("setcpu2_rdy", {31'd0, cpu_rdy}, 32'd0);
    check("setcpu2_valid", {31'd0, valid}, 32'd0);
    cs_high();

    // WRITE aborted after two bytes
    cs_low();
    spi_byte(8'h41, rxb);
    spi_byte(8'h80, rxb);
    check("abort_busy", {31'd0, ready_n}, 32'd1);
    cs_high();
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      if (valid) highs++;
      tick(1);
    end
    check("abort_no_valid", highs, 32'd0);
    check("abort_ready_n", {31'd0, ready_n}, 32'd0);
    check("abort_addr", {15'd0, addr}, 32'h1FFFF);

    // CS_N toggled and SCK clocked during ISSUE; done delayed ~20 cycles
    cs_low();
    spi_byte(8'h41, rxb);
    spi_byte(8'h23, rxb);
    spi_byte(8'h45, rxb);
    spi_byte(8'h67, rxb);
    wait_valid("tog_valid");
    tick(4); cs_n = 1'b1;
    tick(4); cs_n = 1'b0;
    tick(2);
    for (int k = 0; k < 2; k++) begin
      mosi = 1'b1; sck = 1'b1; tick(2); sck = 1'b0; tick(2);
    end
    cs_n = 1'b1;
    tick(4);
    check("tog_valid_held", {31'd0, valid}, 32'd1);
    check("tog_addr", {15'd0, addr}, 32'h12345);
    check("tog_data", {24'd0, wdata}, 32'h67);
    check("tog_rw", {31'd0, rw_n}, 32'd0);
    pulse_done(8'h00);
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      if (valid) highs++;
      tick(1);
    end
    check("tog_single", highs, 32'd0);
    check("tog_ready_n", {31'd0, ready_n}, 32'd0);

    // Reset asserted mid-ISSUE
    cs_low();
    spi_byte(8'h40, rxb);
    spi_byte(8'h00, rxb);
    spi_byte(8'h01, rxb);
    spi_byte(8'h99, rxb);
    wait_valid("rmid_valid");
    rst_n = 1'b0;
    #1;
    check("rmid_valid_drop", {31'd0, valid}, 32'd0);
    check("rmid_rw", {31'd0, rw_n}, 32'd1);
    check("rmid_addr", {15'd0, addr}, 32'd0);
    check("rmid_data", {24'd0, wdata}, 32'd0);
    check("rmid_ready_n", {31'd0, ready_n}, 32'd1);
    check("rmid_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rmid_cpu_rdy", {31'd0, cpu_rdy}, 32'd0);
    check("rmid_oe_low_cs", {31'd0, miso_oe}, 32'd1);
    tick(2);
    cs_n = 1'b1;
    #1;
    check("rmid_oe_high_cs", {31'd0, miso_oe}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("rmid_post_ready_n", {31'd0, ready_n}, 32'd0);
    check("rmid_post_valid", {31'd0, valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi1_cmd_target.md
SPI1_CMD_TARGET -- requirements
Module: spi1_cmd_target

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, SCK/CS_N/MOSI synchronizer depth in clk16_i cycles.
REQ-002 SHALL have ports:
- clk16_i  in  1  system clock, 16 MHz; one clock only
- reset_ni  in  1  asynchronous, active-low reset
- spi1_sck_i  in  1  SPI clock from MCU; mode 0; max 4 MHz
- spi1_cs_ni  in  1  SPI chip select, active low
- spi1_mcu_tx_i  in  1  MOSI, MSB first
- spi1_mcu_rx_o  out  1  MISO
- spi1_mcu_rx_oe  out  1  MISO output enable
- spi_ready_no  out  1  low = idle, next command accepted
- bus_addr_o  out  17  transaction address
- bus_data_o  out  8  write data
- bus_rw_no  out  1  1 = read, 0 = write
- bus_valid_o  out  1  transaction request
- bus_done_i  in  1  one-cycle completion pulse from arbiter
- bus_data_i  in  8  read data, valid with bus_done_i
- cpu_reset_o  out  1  hold CPU in reset
- cpu_ready_o  out  1  CPU RDY

Function
REQ-003 SHALL drive spi1_mcu_rx_oe = !spi1_cs_ni combinationally, with no synchronizer delay.
REQ-004 SHALL sample MOSI on each detected synchronized SCK rising edge; SHALL shift the next MISO bit on the same detected edge.
REQ-005 SHALL load the MISO shift register from rd_data while CS_N is high, so bit 7 is valid when CS_N falls.
REQ-006 SHALL interpret cmd byte [7:6] = op and [0] = addr bit 16:
- op 00 = READ: cmd, addr_hi, addr_lo (3 bytes)
- op 01 = WRITE: cmd, addr_hi, addr_lo, data (4 bytes)
- op 11 = SET_CPU: 1 byte; [1] = ready, [0] = reset
- op 10 = reserved, ignored
REQ-007 SHALL use FSM IDLE -> RECV (first SCK edge with CS_N low) -> ISSUE (final bit of READ/WRITE) -> IDLE (bus_done_i). SET_CPU and reserved ops SHALL go RECV -> IDLE.
REQ-008 SHALL raise bus_valid_o 1 cycle after the final bit is sampled, with addr/data/rw stable, and hold it until bus_done_i; SHALL drop it the cycle after bus_done_i.
REQ-009 SHALL latch bus_data_i into rd_data on bus_done_i for READ only.
REQ-010 SHALL update cpu_reset_o/cpu_ready_o 1 cycle after the 8th bit of SET_CPU.
REQ-011 SHALL drive spi_ready_no high from the first sampled bit until return to IDLE.
REQ-012 A CS_N rise during RECV SHALL abort to IDLE: partial bytes discarded, no request issued, outputs unchanged.
REQ-013 A CS_N rise or fall during ISSUE SHALL NOT affect the pending request; bits clocked during ISSUE SHALL be ignored.
REQ-014 Extra bytes after a command completes within one CS_N assertion SHALL be ignored.
REQ-015 Bit and byte counters SHALL reset on every CS_N fall.

Reset
REQ-016 While reset_ni is low, outputs SHALL be: bus_valid_o=0, bus_rw_no=1, bus_addr_o=0, bus_data_o=0, spi_ready_no=1, cpu_reset_o=1, cpu_ready_o=0, rd_data=0, FSM=IDLE.
REQ-017 After reset_ni deasserts, spi_ready_no SHALL go low within SYNC_STAGES+1 cycles.
REQ-018 Reset asserted during ISSUE SHALL drop bus_valid_o immediately (asynchronous).

Structure
REQ-019 Package pet_spi_pkg SHALL hold the op enum, per-op byte counts, and the SET_CPU bit positions.
REQ-020 One sub-module, sync2 (parameterized depth), SHALL synchronize SCK, CS_N and MOSI.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- WRITE 0x41,0x80,0x00,0x5A -> bus_valid_o, addr=0x18000, rw=0, data=0x5A; done -> spi_ready_no low.
- READ 0x00,0xE8,0x10, done with 0xC3 -> next transaction MISO first byte = 0xC3.
- SET_CPU 0xC2 -> cpu_reset_o=0, cpu_ready_o=1; then 0xC1 -> reset=1, ready=0.
- WRITE aborted after 2 bytes (CS_N high) -> no bus_valid_o, spi_ready_no low.
- CS_N toggled during ISSUE, done delayed 20 cycles -> request held unchanged, single completion.
- Reset mid-ISSUE -> all REQ-016 values immediately; rx_oe tracks !cs_n throughout.
